count_sweep_ctrl: RTL
=====================

# count_sweep_ctrl

Downstream readout controller for the per-output packet counter bank (`contador`). On a start command, and only while the datapath is idle, it sweeps every counter index in order. For each index it:
- issues a one-cycle `req` with `idx`;
- waits for `valid_cont`/`data_cont`;
- forwards each count as a tagged, one-cycle result beat.

Missing responses are bounded by a timeout and flagged.

## Interface
- `DATA_WIDTH`, 8, width of `data_cont` and `cnt_data`
- `IDX_WIDTH`, 2, width of `idx`/`cnt_idx`
- `NUM_CNT`, 4, number of counters swept (≤ 2**IDX_WIDTH)
- `TIMEOUT`, 15, max WAIT cycles per index before giving up (≥ 1)

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  sweep request, sampled in IDLE only
- `idle`  in  1  datapath idle; a sweep starts only with `start && idle`
- `valid_cont`  in  1  counter response valid
- `data_cont`  in  DATA_WIDTH  counter response value
- `req`  out  1  read request to counter bank
- `idx`  out  IDX_WIDTH  counter index being read
- `cnt_valid`  out  1  one-cycle result strobe
- `cnt_data`  out  DATA_WIDTH  captured count
- `cnt_idx`  out  IDX_WIDTH  index of `cnt_data`
- `busy`  out  1  sweep in progress
- `done`  out  1  one-cycle end-of-sweep pulse
- `timeout_err`  out  1  sticky: at least one index timed out in the current/last sweep

## Operation
- All outputs are registered. Reset (asynchronous, any state) forces:
  - state IDLE;
  - `req`, `idx`, `cnt_valid`, `cnt_data`, `cnt_idx`, `busy`, `done`, `timeout_err` = 0;
  - WAIT timer = 0.
- FSM states: IDLE, REQ, WAIT, NEXT, DONE.
- IDLE
  - `start && idle` → REQ, with `idx` = 0 and `timeout_err` cleared.
  - `start` with `idle` = 0 is dropped; it is not latched.
- REQ
  - `req` = 1 for exactly one cycle.
  - → WAIT, timer = 0.
- WAIT
  - Response, `valid_cont` = 1:
    - capture `data_cont` → `cnt_data`, `idx` → `cnt_idx`;
    - `cnt_valid` = 1 the following cycle;
    - → DONE if `idx` == NUM_CNT-1, else → NEXT.
  - No response:
    - timer increments each cycle;
    - when timer == TIMEOUT-1 with `valid_cont` = 0, set `timeout_err`, emit no `cnt_valid`, and take the same NEXT/DONE decision.
- NEXT
  - `idx` ← `idx` + 1 → REQ.
  - This guarantees at least two non-request cycles between `req` pulses.
- DONE
  - `done` = 1 for one cycle → IDLE. `idx` holds its last value.
- `busy` = 1 in every state except IDLE.
- `valid_cont` is ignored in IDLE, NEXT and DONE.
  - It is accepted in REQ (same-cycle response) and treated exactly as in WAIT.
  - An extra beat after capture is discarded.
- `start` while `busy` is ignored. `idle` is checked only at sweep start; deassertion mid-sweep does not abort.
- `cnt_data` and `cnt_idx` hold their values between strobes. No arithmetic wrap: `idx` never exceeds NUM_CNT-1.

## Timing
- `start && idle` sampled at edge E0 → `req` = 1, `idx` = 0 in cycle 1.
- Counter responding one cycle after `req` (`valid_cont` in cycle 2) → `cnt_valid` in cycle 3.
- With NEXT at cycle 3, the next `req` comes in cycle 4. Period is 3 cycles per index.
- NUM_CNT=4 with 1-cycle responses:
  - `req` in cycles 1, 4, 7, 10;
  - `cnt_valid` in cycles 3, 6, 9, 12;
  - `done` in cycle 12;
  - `busy` in cycles 1–12, low in cycle 13.
- A timed-out index occupies 1 REQ + TIMEOUT WAIT cycles (+1 NEXT).
- Reset asserted mid-sweep clears outputs immediately (asynchronous). The first new `req` can appear 2 cycles after reset release plus `start`.

## Test plan
- Reset with `start` = 1 held → all outputs 0. After release with `idle` = 1, `req` rises one cycle after the first sampled `start`.
- Counter model returning 3, 7, 0, 255 for idx 0–3 with 1-cycle latency:
  - `cnt_valid` beats (idx, data) = (0,3), (1,7), (2,0), (3,255) in cycles 3/6/9/12;
  - `done` in cycle 12;
  - `timeout_err` = 0.
- `start` with `idle` = 0 for 5 cycles, then `idle` = 1 with `start` = 0 → no `req`, `busy` stays 0.
- Model silent for idx 2, TIMEOUT = 15:
  - no beat for idx 2;
  - `timeout_err` = 1 after 15 WAIT cycles;
  - sweep continues to idx 3 and `done`;
  - next accepted `start` clears `timeout_err`.
- Reset pulse while waiting on idx 1 → outputs 0 in the same cycle, FSM in IDLE. A fresh sweep restarts at idx 0.
- Stray `valid_cont` in IDLE, plus a second `valid_cont` beat after capture → no extra `cnt_valid`. Pulsing `start` while `busy` neither restarts nor extends the sweep.

Source files
------------

// File: rtl/count_sweep_ctrl.sv
// count_sweep_ctrl
//
// Readout controller for the per-output packet counter bank. A sweep starts on
// start && idle. It walks every counter index in order, issuing a one-cycle
// read request for each. Each response is forwarded as a tagged one-cycle
// result beat. An index that never answers is abandoned after TIMEOUT wait
// cycles, and the sticky timeout flag is set.
//
// Ports:
//   clk          single clock, rising edge
//   reset        asynchronous, active-high reset
//   start        sweep request, sampled only while idle in IDLE
//   idle         datapath idle qualifier for start
//   valid_cont   counter response valid
//   data_cont    counter response value
//   req          one-cycle read request to the counter bank
//   idx          counter index being read
//   cnt_valid    one-cycle result strobe
//   cnt_data     captured count, held between strobes
//   cnt_idx      index of cnt_data, held between strobes
//   busy         sweep in progress
//   done         one-cycle end-of-sweep pulse
//   timeout_err  sticky: an index timed out in the current/last sweep
module count_sweep_ctrl #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned IDX_WIDTH  = 2,
   parameter int unsigned NUM_CNT    = 4,
   parameter int unsigned TIMEOUT    = 15
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  idle,
   input  logic                  valid_cont,
   input  logic [DATA_WIDTH-1:0] data_cont,
   output logic                  req,
   output logic [IDX_WIDTH-1:0]  idx,
   output logic                  cnt_valid,
   output logic [DATA_WIDTH-1:0] cnt_data,
   output logic [IDX_WIDTH-1:0]  cnt_idx,
   output logic                  busy,
   output logic                  done,
   output logic                  timeout_err
);

   // Wide enough to hold TIMEOUT-1 even when TIMEOUT is 1.
   localparam int unsigned TMR_WIDTH = $clog2(TIMEOUT + 1);
   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CNT - 1);
   localparam logic [TMR_WIDTH-1:0] TMR_LAST = TMR_WIDTH'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StWait,
      StNext,
      StDone
   } state_e;

   state_e                 state;
   logic [TMR_WIDTH-1:0]   timer;
   logic                   last_idx;

   assign last_idx = (idx == LAST_IDX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= StIdle;
         timer       <= '0;
         req         <= 1'b0;
         idx         <= '0;
         cnt_valid   <= 1'b0;
         cnt_data    <= '0;
         cnt_idx     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         // Pulse outputs default low every cycle.
         req       <= 1'b0;
         cnt_valid <= 1'b0;
         done      <= 1'b0;
         unique case (state)
            StIdle: begin
               // A start without idle is simply dropped, not remembered.
               if (start && idle) begin
                  state       <= StReq;
                  req         <= 1'b1;
                  idx         <= '0;
                  busy        <= 1'b1;
                  timeout_err <= 1'b0;
               end
            end
            // A same-cycle response during REQ is handled exactly like one in WAIT.
            StReq, StWait: begin
               if (valid_cont) begin
                  cnt_valid <= 1'b1;
                  cnt_data  <= data_cont;
                  cnt_idx   <= idx;
                  if (last_idx) begin
                     state <= StDone;
                     done  <= 1'b1;
                  end else begin
                     state <= StNext;
                  end
               end else if (state == StReq) begin
                  state <= StWait;
                  timer <= '0;
               end else if (timer == TMR_LAST) begin
                  // Give up on this index; no result beat is emitted for it.
                  timeout_err <= 1'b1;
                  if (last_idx) begin
                     state <= StDone;
                     done  <= 1'b1;
                  end else begin
                     state <= StNext;
                  end
               end else begin
                  timer <= timer + TMR_WIDTH'(1);
               end
            end
            // Only reached when idx < NUM_CNT-1, so idx never runs past the bank.
            StNext: begin
               idx   <= idx + IDX_WIDTH'(1);
               req   <= 1'b1;
               state <= StReq;
            end
            StDone: begin
               busy  <= 1'b0;
               state <= StIdle;
            end
            default: begin
               state <= StIdle;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
